// File: rtl/mux_word_pipe_pkg.sv
// Shared constants and helpers for the word selector pipeline and its
// sibling parametrised datapath blocks.
package mux_word_pipe_pkg;

  localparam logic MUX_MODE_DIRECT = 1'b0;
  localparam logic MUX_MODE_SCAN   = 1'b1;

  // Ceiling log2, usable in constant expressions; callers guarantee n >= 2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_word_pipe_if.sv
// Request/response bundle for mux_word_pipe: packed channel inputs, select,
// mode and both valid/ready handshakes.
interface mux_word_pipe_if
  import mux_word_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 16
);
  localparam int unsigned SEL_W = clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_err;
  logic                      out_wrap;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in, sel, mode, in_valid, out_ready,
    input  in_ready, out, out_sel, out_err, out_wrap, out_valid
  );

  modport slave (
    input  in, sel, mode, in_valid, out_ready,
    output in_ready, out, out_sel, out_err, out_wrap, out_valid
  );

endinterface

// File: rtl/mux_word.sv
// Combinational CHANNELS:1 selector of WIDTH-bit words; indices past the last
// channel give a zero word and deassert in_range_o.
module mux_word
  import mux_word_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] in_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [WIDTH-1:0]          word_o,
  output logic                      in_range_o
);

  always_comb begin
    word_o     = '0;
    in_range_o = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel_i == SEL_W'(k)) begin
        word_o     = in_i[k*WIDTH +: WIDTH];
        in_range_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_word_pipe.sv
// One-stage valid/ready register around a word selector, with a wrap-around
// channel scanner for sweeping bus sources in test and debug.
module mux_word_pipe
  import mux_word_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 16
) (
  input logic            clock,
  input logic            reset_n,
  mux_word_pipe_if.slave bus
);
  localparam int unsigned SEL_W = clog2(CHANNELS);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] word;
  logic             in_range;
  logic             in_ready;
  logic             accept;
  logic             scan_mode;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_err_q, out_err_d;
  logic             out_wrap_q, out_wrap_d;
  logic             out_valid_q, out_valid_d;

  // No skid buffer: a stalled output blocks the input directly.
  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign scan_mode = (bus.mode == MUX_MODE_SCAN);
  assign idx       = scan_mode ? scan_idx_q : bus.sel;

  mux_word #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_mux_word (
    .in_i       (bus.in),
    .sel_i      (idx),
    .word_o     (word),
    .in_range_o (in_range)
  );

  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_wrap_d  = out_wrap_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = word;
      out_sel_d   = idx;
      out_err_d   = !in_range;
      out_wrap_d  = scan_mode && (idx == LastIdx);
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Direct mode parks the scanner at 0 so entering scan always starts there.
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (bus.mode == MUX_MODE_DIRECT) begin
      scan_idx_d = '0;
    end else if (accept) begin
      scan_idx_d = (scan_idx_q == LastIdx) ? '0 : scan_idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_wrap_q  <= 1'b0;
      out_valid_q <= 1'b0;
      scan_idx_q  <= '0;
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_wrap_q  <= out_wrap_d;
      out_valid_q <= out_valid_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_wrap  = out_wrap_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_word_pipe.sv
// Scoreboard bench for mux_word_pipe: a 16-channel and a 12-channel instance
// driven by directed scenarios and then random traffic.
module tb_mux_word_pipe;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  sel;
    logic        err;
    logic        wrap;
  } exp_t;

  logic clock;
  logic reset_n;

  logic [255:0] drv_in  [2];
  logic [3:0]   drv_sel [2];
  logic         drv_mode[2];
  logic         drv_vld [2];
  logic         drv_rdy [2];

  logic [15:0]  obs_out [2];
  logic [3:0]   obs_sel [2];
  logic         obs_err [2];
  logic         obs_wrap[2];
  logic         obs_vld [2];
  logic         obs_irdy[2];

  exp_t exp_q [2][$];
  exp_t last_e[2];
  int   scan  [2];
  int   nch   [2];
  int   checks;
  int   failures;

  mux_word_pipe_if #(.WIDTH(16), .CHANNELS(16)) bus0 ();
  mux_word_pipe_if #(.WIDTH(16), .CHANNELS(12)) bus1 ();

  mux_word_pipe #(.WIDTH(16), .CHANNELS(16)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  mux_word_pipe #(.WIDTH(16), .CHANNELS(12)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  assign bus0.in        = drv_in[0];
  assign bus0.sel       = drv_sel[0];
  assign bus0.mode      = drv_mode[0];
  assign bus0.in_valid  = drv_vld[0];
  assign bus0.out_ready = drv_rdy[0];
  assign bus1.in        = drv_in[1][191:0];
  assign bus1.sel       = drv_sel[1];
  assign bus1.mode      = drv_mode[1];
  assign bus1.in_valid  = drv_vld[1];
  assign bus1.out_ready = drv_rdy[1];

  assign obs_out[0]  = bus0.out;
  assign obs_sel[0]  = bus0.out_sel;
  assign obs_err[0]  = bus0.out_err;
  assign obs_wrap[0] = bus0.out_wrap;
  assign obs_vld[0]  = bus0.out_valid;
  assign obs_irdy[0] = bus0.in_ready;
  assign obs_out[1]  = bus1.out;
  assign obs_sel[1]  = bus1.out_sel;
  assign obs_err[1]  = bus1.out_err;
  assign obs_wrap[1] = bus1.out_wrap;
  assign obs_vld[1]  = bus1.out_valid;
  assign obs_irdy[1] = bus1.in_ready;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h expected=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference model: chosen index, word and flags straight from the handshake rules.
  function automatic exp_t model_word(input int d);
    exp_t e;
    int   idx;
    idx    = drv_mode[d] ? scan[d] : int'(drv_sel[d]);
    e.data = (idx < nch[d]) ? drv_in[d][idx*16 +: 16] : 16'h0;
    e.sel  = 4'(idx);
    e.err  = (idx >= nch[d]);
    e.wrap = drv_mode[d] && (idx == nch[d] - 1);
    return e;
  endfunction

  // Called at posedge+2 with inputs already set; returns at next posedge+2.
  task automatic step();
    logic acc[2];
    exp_t e  [2];
    for (int d = 0; d < 2; d++) begin
      acc[d] = drv_vld[d] && (exp_q[d].size() == 0 || drv_rdy[d]);
      e[d]   = model_word(d);
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) exp_q[d].push_back(e[d]);
      if (!drv_mode[d]) scan[d] = 0;
      else if (acc[d]) scan[d] = (scan[d] + 1) % nch[d];
    end
    #2;
  endtask

  task automatic set_both(input logic vld, input logic rdy, input logic mode,
                          input logic [3:0] sel0, input logic [3:0] sel1);
    drv_vld[0] = vld;  drv_vld[1] = vld;
    drv_rdy[0] = rdy;  drv_rdy[1] = rdy;
    drv_mode[0] = mode; drv_mode[1] = mode;
    drv_sel[0] = sel0; drv_sel[1] = sel1;
  endtask

  // Monitor: at mid-cycle, compare the presented word with the queue head and
  // retire it when downstream takes it at the coming edge.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (exp_q[d].size() != 0) begin
        check("out_valid", d, 32'(obs_vld[d]), 32'd1);
        check("out", d, 32'(obs_out[d]), 32'(exp_q[d][0].data));
        check("out_sel", d, 32'(obs_sel[d]), 32'(exp_q[d][0].sel));
        check("out_err", d, 32'(obs_err[d]), 32'(exp_q[d][0].err));
        check("out_wrap", d, 32'(obs_wrap[d]), 32'(exp_q[d][0].wrap));
        check("in_ready_busy", d, 32'(obs_irdy[d]), 32'(drv_rdy[d]));
        if (drv_rdy[d]) begin
          last_e[d] = exp_q[d][0];
          void'(exp_q[d].pop_front());
        end
      end else begin
        check("out_valid_idle", d, 32'(obs_vld[d]), 32'd0);
        check("in_ready_idle", d, 32'(obs_irdy[d]), 32'd1);
        check("out_held", d, 32'(obs_out[d]), 32'(last_e[d].data));
        check("out_sel_held", d, 32'(obs_sel[d]), 32'(last_e[d].sel));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_valid"}, d, 32'(obs_vld[d]), 32'd0);
      check({tag, "_out"}, d, 32'(obs_out[d]), 32'd0);
      check({tag, "_sel"}, d, 32'(obs_sel[d]), 32'd0);
      check({tag, "_err"}, d, 32'(obs_err[d]), 32'd0);
      check({tag, "_wrap"}, d, 32'(obs_wrap[d]), 32'd0);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      last_e[d] = '0;
      scan[d]   = 0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nch[0]   = 16;
    nch[1]   = 12;
    model_reset();
    reset_n = 1'b0;
    drv_in[0] = '0;
    drv_in[1] = '0;
    for (int k = 0; k < 16; k++) begin
      drv_in[0][k*16 +: 16] = 16'h1000 + 16'(k);
      drv_in[1][k*16 +: 16] = 16'h2000 + 16'(k);
    end
    set_both(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    #3;
    check_reset_outputs("reset");
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // Direct select of channel 5 on both instances.
    set_both(1'b1, 1'b1, 1'b0, 4'd5, 4'd5);
    step();
    set_both(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step();

    // Backpressure: sel=3 captured, then a 4-cycle stall with sel=9 waiting.
    set_both(1'b1, 1'b1, 1'b0, 4'd3, 4'd3);
    step();
    set_both(1'b1, 1'b0, 1'b0, 4'd9, 4'd9);
    repeat (4) step();
    set_both(1'b1, 1'b1, 1'b0, 4'd9, 4'd9);
    step();
    set_both(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step();

    // Scan 18 words: wraps after the last channel of each instance.
    set_both(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    repeat (18) step();
    set_both(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step();

    // Out-of-range select on the 12-channel instance, then its last channel.
    set_both(1'b1, 1'b1, 1'b0, 4'd13, 4'd13);
    step();
    set_both(1'b1, 1'b1, 1'b0, 4'd11, 4'd11);
    step();
    set_both(1'b1, 1'b1, 1'b0, 4'd15, 4'd12);
    step();
    set_both(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step();

    // Mode switch while stalled: held word unchanged, first scan is channel 0.
    set_both(1'b1, 1'b0, 1'b0, 4'd7, 4'd7);
    step();
    set_both(1'b1, 1'b0, 1'b1, 4'd2, 4'd2);
    repeat (3) step();
    set_both(1'b1, 1'b1, 1'b1, 4'd2, 4'd2);
    repeat (3) step();

    // Reset mid-stall: outputs drop at once, scan restarts at channel 0.
    set_both(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("stall_reset");
    model_reset();
    set_both(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    #1;
    step();
    reset_n = 1'b1;
    set_both(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    repeat (2) step();

    // Random traffic; inputs change every cycle to catch late sampling.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 16; k++) drv_in[d][k*16 +: 16] = 16'($urandom);
        drv_vld[d] = ($urandom_range(9, 0) < 7);
        drv_rdy[d] = ($urandom_range(9, 0) < 7);
        drv_sel[d] = 4'($urandom_range(15, 0));
        if ($urandom_range(7, 0) == 0) drv_mode[d] = ~drv_mode[d];
      end
      step();
    end

    set_both(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    repeat (3) step();
    for (int d = 0; d < 2; d++) check("drained", d, 32'(exp_q[d].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
